// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline register sequencer: load-use, branch flush, memory wait and timeout
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wcnt;
    logic [15:0] wcnt_nxt;
    logic        err_nxt;

    logic        mem_req;
    logic        freeze;
    logic        lu;
    logic        rs_hit;
    logic        rt_hit;
    logic        branch_row;

    // Hazard detection terms from the ID stage and pipeline register outputs
    always_comb begin
        mem_req = exmem_memread | exmem_memwrite;
        rs_hit  = id_use_rs & (id_rs == idex_rt);
        rt_hit  = id_use_rt & (id_rt == idex_rt);
        lu      = idex_memread & (idex_rt != 5'd0) & (rs_hit | rt_hit);
        freeze  = ((state == RUN) & mem_req & ~dmem_ready)
                | ((state == MEM_WAIT) & ~dmem_ready)
                | (state == ERROR);
    end

    // Register enables and flushes, prioritised freeze > branch > load-use > normal
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        branch_row  = 1'b0;
        if (reset) begin
            // everything held low while the pipeline is being reset
            pc_en = 1'b0;
        end else if (freeze) begin
            // EX and ID keep their instructions; MEM/WB drains a bubble
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            branch_row = 1'b1;
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else if (lu) begin
            // hold PC and IF/ID one cycle, insert a single bubble into ID/EX
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
        end
    end

    // Next-state logic for the memory wait sequencer and its watchdog
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        err_nxt   = err;
        case (state)
            RUN: begin
                if (mem_req & ~dmem_ready) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = 16'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wcnt_nxt  = 16'd0;
                end else if (wcnt == TIMEOUT_W) begin
                    state_nxt = ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + 16'd1;
                end
            end
            ERROR: begin
                // only reset leaves this state
                err_nxt = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = 16'd0;
            end
        endcase
    end

    // State, wait counter and sticky error register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= 16'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            err   <= err_nxt;
        end
    end

    // Saturating stall and branch-flush performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (~pc_en && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_row && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush}
    localparam logic [7:0] P_RST  = 8'b0000_0000;
    localparam logic [7:0] P_FRZ  = 8'b0000_0011;
    localparam logic [7:0] P_BR   = 8'b1111_1110;
    localparam logic [7:0] P_LU   = 8'b0001_1110;
    localparam logic [7:0] P_NORM = 8'b1101_0110;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             ex_branch_taken;
    logic             exmem_memread;
    logic             exmem_memwrite;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             memwb_flush;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0]       outs;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .ex_branch_taken(ex_branch_taken),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .memwb_flush    (memwb_flush),
        .err            (err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        id_use_rs       = 1'b0;
        id_use_rt       = 1'b0;
        idex_memread    = 1'b0;
        idex_rt         = 5'd0;
        ex_branch_taken = 1'b0;
        exmem_memread   = 1'b0;
        exmem_memwrite  = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic set_lu8();
        idex_memread = 1'b1;
        idex_rt      = 5'd8;
        id_use_rs    = 1'b1;
        id_rs        = 5'd8;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_outs", 16'(outs), 16'(P_RST));
        chk("rst_stall_cnt", 16'(stall_cnt), 16'd0);
        chk("rst_flush_cnt", 16'(flush_cnt), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("run_idle", 16'(outs), 16'(P_NORM));

        // load-use on rs
        set_lu8();
        #1;
        chk("lu_rs", 16'(outs), 16'(P_LU));
        tick();
        idex_memread = 1'b0;
        #1;
        chk("lu_release", 16'(outs), 16'(P_NORM));
        chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);

        // register 0 load never stalls
        idex_memread = 1'b1;
        idex_rt      = 5'd0;
        id_rs        = 5'd0;
        id_use_rs    = 1'b1;
        #1;
        chk("r0_no_stall", 16'(outs), 16'(P_NORM));
        tick();
        chk("r0_stall_cnt", 16'(stall_cnt), 16'd1);

        // match only counts when the operand is actually read
        idex_rt   = 5'd5;
        id_rs     = 5'd5;
        id_rt     = 5'd5;
        id_use_rs = 1'b0;
        id_use_rt = 1'b0;
        #1;
        chk("lu_unused", 16'(outs), 16'(P_NORM));
        id_use_rt = 1'b1;
        #1;
        chk("lu_rt", 16'(outs), 16'(P_LU));
        tick();
        clear_inputs();
        #1;
        chk("lu_rt_stall_cnt", 16'(stall_cnt), 16'd2);

        // asynchronous reset clears counters immediately
        reset = 1'b1;
        #1;
        chk("rst_async_stall", 16'(stall_cnt), 16'd0);
        chk("rst_async_outs", 16'(outs), 16'(P_RST));
        @(negedge clk);
        reset = 1'b0;
        #1;

        // branch beats load-use
        set_lu8();
        ex_branch_taken = 1'b1;
        #1;
        chk("br_over_lu", 16'(outs), 16'(P_BR));
        tick();
        clear_inputs();
        #1;
        chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
        chk("br_stall_cnt", 16'(stall_cnt), 16'd0);

        // memory wait, three frozen cycles then ready
        exmem_memread = 1'b1;
        #1;
        chk("mw_c1", 16'(outs), 16'(P_FRZ));
        tick();
        ex_branch_taken = 1'b1;
        #1;
        chk("mw_c2_br_ignored", 16'(outs), 16'(P_FRZ));
        tick();
        ex_branch_taken = 1'b0;
        exmem_memread   = 1'b0;
        #1;
        chk("mw_c3_in_wait", 16'(outs), 16'(P_FRZ));
        tick();
        chk("mw_stall_cnt", 16'(stall_cnt), 16'd3);
        chk("mw_flush_kept", 16'(flush_cnt), 16'd1);
        exmem_memread   = 1'b1;
        dmem_ready      = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        chk("mw_release_br", 16'(outs), 16'(P_BR));
        tick();
        clear_inputs();
        #1;
        chk("mw_back_run", 16'(outs), 16'(P_NORM));
        chk("mw_stall_after", 16'(stall_cnt), 16'd3);
        chk("mw_flush_after", 16'(flush_cnt), 16'd2);

        // watchdog: err after the fifth edge of an unanswered request
        exmem_memwrite = 1'b1;
        repeat (4) tick();
        chk("to_err_edge4", 16'(err), 16'd0);
        chk("to_frozen_edge4", 16'(outs), 16'(P_FRZ));
        tick();
        chk("to_err_edge5", 16'(err), 16'd1);
        dmem_ready = 1'b1;
        #1;
        chk("to_ready_ignored", 16'(outs), 16'(P_FRZ));
        tick();
        chk("to_still_frozen", 16'(outs), 16'(P_FRZ));
        chk("to_err_sticky", 16'(err), 16'd1);
        chk("to_stall_cnt", 16'(stall_cnt), 16'd9);
        reset = 1'b1;
        #1;
        chk("to_rst_outs", 16'(outs), 16'(P_RST));
        chk("to_rst_err", 16'(err), 16'd0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("to_rst_run", 16'(outs), 16'(P_NORM));

        // reset in the middle of a wait returns to RUN
        exmem_memread = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        exmem_memread = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mw_rst_run", 16'(outs), 16'(P_NORM));

        // saturation of both counters at 15
        set_lu8();
        repeat (14) tick();
        chk("sat_stall_14", 16'(stall_cnt), 16'd14);
        repeat (6) tick();
        chk("sat_stall_15", 16'(stall_cnt), 16'd15);
        clear_inputs();
        ex_branch_taken = 1'b1;
        repeat (20) tick();
        chk("sat_flush_15", 16'(flush_cnt), 16'd15);
        chk("sat_stall_hold", 16'(stall_cnt), 16'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Detects load-use hazards and taken-branch redirects.
- Handles data-memory wait states, with a timeout watchdog.
- Drives a per-register enable/flush pair and the PC enable.
- Keeps saturating stall and flush performance counters.
- Sits beside the datapath: its inputs come from the ID stage and the ID/EX and EX/MEM register outputs, and its outputs go to the register enable/flush pins.

Parameters:
TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERROR (legal range 1..65535)
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
idex_memread  in  1  MemRead control bit at the ID/EX output
idex_rt  in  5  load destination register at the ID/EX output
ex_branch_taken  in  1  branch/jump resolved taken in EX
exmem_memread  in  1  MemRead control bit at the EX/MEM output
exmem_memwrite  in  1  MemWrite control bit at the EX/MEM output
dmem_ready  in  1  data memory completes the current access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID clear to bubble
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX control bits cleared (bubble)
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
memwb_flush  out  1  MEM/WB control bits cleared
err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating
flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- State register values: RUN, MEM_WAIT, ERROR. Wait counter wcnt is 16 bits.
- Reset: state=RUN, wcnt=0, err=0, stall_cnt=0, flush_cnt=0.
- While reset is high, every en and flush output is 0.
- All en/flush outputs are combinational from state and current inputs. There is zero-cycle latency from a hazard to the stall.
- Derived signals:
  - mem_req = exmem_memread | exmem_memwrite
  - freeze = (state==RUN & mem_req & !dmem_ready) | (state==MEM_WAIT & !dmem_ready) | state==ERROR
  - lu = idex_memread & idex_rt!=0 & ((id_use_rs & id_rs==idex_rt) | (id_use_rt & id_rt==idex_rt))
- Output priority, highest first:
  1. freeze: pc_en, ifid_en, idex_en, exmem_en, memwb_en = 0,0,0,0,1 and memwb_flush=1. All other flushes 0. Branch and load-use are ignored; they re-evaluate after release because EX and ID hold their instructions.
  2. ex_branch_taken: all en=1, ifid_flush=1, idex_flush=1, memwb_flush=0. The PC loads the target.
  3. lu: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. Exactly one bubble per load-use.
  4. Otherwise: all en=1, all flush=0.
- When a flush and an enable are both 1 on the same register, the flush wins inside that register.
- State transitions:
  - RUN: mem_req & !dmem_ready -> MEM_WAIT with wcnt=1. Otherwise stay in RUN.
  - MEM_WAIT, dmem_ready=1: release is in the same cycle (freeze=0, normal priority applies), next state RUN, wcnt=0.
  - MEM_WAIT, dmem_ready=0 and wcnt==TIMEOUT: -> ERROR, err=1.
  - MEM_WAIT, otherwise: wcnt+1.
  - ERROR: pipeline frozen and err=1 until reset. dmem_ready has no effect.
- Counters (saturating):
  - stall_cnt +1 on each clock edge where pc_en=0 and reset is low.
  - flush_cnt +1 on each edge where the branch-priority row is active.
  - Each holds at 2^CNT_W-1.
- idex_rt=0 never causes a load-use stall.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN at once.

Test Plan:
1. Load-use: idex_memread=1, idex_rt=8, id_use_rs=1, id_rs=8, one cycle.
   - That cycle: pc_en=0, ifid_en=0, idex_flush=1.
   - Next cycle (idex_memread=0): all en=1. stall_cnt=1.
2. Register-0 load: idex_rt=0, id_rs=0, id_use_rs=1 -> no stall, pc_en=1, stall_cnt unchanged.
3. Branch plus load-use in the same cycle: ex_branch_taken=1 with lu true.
   - Response: pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt=1, stall_cnt=0.
4. Memory wait: exmem_memread=1, dmem_ready=0 for 3 cycles, then 1.
   - Cycles 1-3: all en 0 except memwb_en=1, memwb_flush=1. State MEM_WAIT after the first edge.
   - Ready cycle: all en=1, state RUN. stall_cnt=3.
5. Timeout: TIMEOUT=4, exmem_memwrite=1, dmem_ready held 0.
   - err=1 after the 5th edge of the request. Pipeline stays frozen even after dmem_ready=1.
   - Reset clears err and returns state to RUN.
6. Counter saturation: CNT_W=4, hold lu for 20 cycles -> stall_cnt stops at 15.
